// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants for the HI/LO multiply/divide unit.
// Op encoding, FSM state encoding, datapath width and divide-by-zero LO value.
// 3'b111 is reserved and decodes as a NOP.
package hilo_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_iter_step.sv
// hilo_iter_step: one shift-add multiply step or one restoring-divide step.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module hilo_iter_step
  import hilo_pkg::*;
(
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] opnd_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           diff_unused;

  // Multiply: {acc,opnd} is the running product shifted right each step.
  assign sum = {1'b0, acc} + {1'b0, mcand};
  // Divide: acc is the partial remainder, opnd shifts the dividend out and quotient in.
  assign shifted = {acc, opnd[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};
  // Remainder stays below the divisor, so the top difference bit is always zero when taken.
  assign diff_unused = diff[WIDTH];

  // Select the next accumulator/operand pair for the active operation.
  always_comb begin
    acc_nxt  = acc;
    opnd_nxt = opnd;
    if (is_div) begin
      if (shifted >= {1'b0, mcand}) begin
        acc_nxt  = diff[WIDTH-1:0];
        opnd_nxt = {opnd[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted[WIDTH-1:0];
        opnd_nxt = {opnd[WIDTH-2:0], 1'b0};
      end
    end else if (opnd[0]) begin
      acc_nxt  = sum[WIDTH:1];
      opnd_nxt = {sum[0], opnd[WIDTH-1:1]};
    end else begin
      acc_nxt  = {1'b0, acc[WIDTH-1:1]};
      opnd_nxt = {acc[0], opnd[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO writes.
// Latency: 33 edges start->done (32 RUN + 1 FIX); MTHI/MTLO take effect at the start edge.
// Backpressure: busy while not IDLE; start is ignored while busy. HILO_FAST_MULT_EN: 1-cycle mult.
module hilo_muldiv
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [4:0]         count;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   mcand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;

  logic               mult_op;
  logic               div_op;
  logic               signed_op;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   opnd_nxt;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy      = (state != S_IDLE);
  assign mult_op   = (op == OP_MULT) || (op == OP_MULTU);
  assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_abs    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Sign correction applied in FIX. 0x80000000 survives abs/negate unchanged, so
  // DIV 0x80000000/-1 yields 0x80000000 without any special case.
  assign prod_mag = {acc, opnd};
  assign prod_fix = neg_res ? -prod_mag : prod_mag;
  assign quo_fix  = div0 ? DIV0_LO : (neg_res ? -opnd : opnd);
  // With a zero divisor the remainder path returns |dividend|, re-signed back to rs_val.
  assign rem_fix  = neg_rem ? -acc : acc;

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, rs_abs} * {{WIDTH{1'b0}}, rt_abs};
`endif

  hilo_iter_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .mcand    (mcand),
    .acc_nxt  (acc_nxt),
    .opnd_nxt (opnd_nxt)
  );

  // Control FSM plus HI/LO and iteration datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count   <= 5'd0;
      acc     <= '0;
      opnd    <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end else if (mult_op || div_op) begin
              is_div  <= div_op;
              div0    <= div_op && (rt_val == '0);
              neg_res <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem <= signed_op && rs_val[WIDTH-1];
              count   <= 5'd0;
              acc     <= '0;
              // Multiply shifts the multiplier (rt) through opnd; divide shifts the dividend.
              opnd    <= div_op ? rs_abs : rt_abs;
              mcand   <= div_op ? rt_abs : rs_abs;
              state   <= S_RUN;
`ifdef HILO_FAST_MULT_EN
              if (mult_op) begin
                {acc, opnd} <= fast_prod;
                state       <= S_FIX;
              end
`endif
            end
          end
        end
        S_RUN: begin
          acc  <= acc_nxt;
          opnd <= opnd_nxt;
          if (count == 5'(ITER - 1)) begin
            state <= S_FIX;
          end else begin
            count <= count + 5'd1;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed and randomized checks of hilo_muldiv against an arithmetic model.
// Expected HI/LO come from plain signed/unsigned 64-bit arithmetic; latency from the op class.
// Build with HILO_FAST_MULT_EN defined to check the single-cycle multiply variant.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [2:0]  op     = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m     = 32'd0;
  logic [31:0] lo_m     = 32'd0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result as {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (o)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] o);
`ifdef HILO_FAST_MULT_EN
    if (o == OP_MULT || o == OP_MULTU) return 1;
`endif
    return (o == OP_DIV || o == OP_DIVU) ? 33 : (o == OP_MULT || o == OP_MULTU) ? 33 : 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; if inject, attempt an MTLO 0xAA while the unit is mid-RUN.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    int n;
    int bcnt;
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    if (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU) begin
      r = model(o, a, b);
      n = 0;
      bcnt = 0;
      while (!done && n < 100) begin
        if (busy) bcnt++;
        if (inject && n == 5) begin
          start = 1'b1; op = OP_MTLO; rs_val = 32'hAA;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
      start = 1'b0;
      check_val("latency", 64'(n), 64'(exp_lat(o)));
      check_val("busy_cycles", 64'(bcnt), 64'(exp_lat(o)));
      check_val("done", {63'd0, done}, 64'd1);
      check_val("busy_at_done", {63'd0, busy}, 64'd0);
      check_val("hi", {32'd0, hi}, {32'd0, r[63:32]});
      check_val("lo", {32'd0, lo}, {32'd0, r[31:0]});
      hi_m = r[63:32];
      lo_m = r[31:0];
      @(posedge clk); #1;
      check_val("done_pulse", {63'd0, done}, 64'd0);
    end else begin
      if (o == OP_MTHI) hi_m = a;
      if (o == OP_MTLO) lo_m = a;
      check_val("mt_busy", {63'd0, busy}, 64'd0);
      check_val("mt_done", {63'd0, done}, 64'd0);
      check_val("mt_hi", {32'd0, hi}, {32'd0, hi_m});
      check_val("mt_lo", {32'd0, lo}, {32'd0, lo_m});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(OP_DIVU,  32'd100,       32'd7,         1'b0);
    run_op(OP_DIVU,  32'h64,        32'd0,         1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_MTHI,  32'h1234_5678, 32'd0,         1'b0);
    run_op(OP_MTLO,  32'hCAFE_F00D, 32'd0,         1'b0);
    run_op(3'b111,   32'hDEAD_BEEF, 32'd0,         1'b0);
    run_op(OP_NOP,   32'hDEAD_BEEF, 32'd0,         1'b0);
    run_op(OP_DIVU,  32'd1000,      32'd9,         1'b1);

    // Asynchronous reset in the middle of an iterative operation
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs_val = 32'd12345; rt_val = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("busy_mid", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    check_val("arst_done", {63'd0, done}, 64'd0);
    check_val("arst_hi", {32'd0, hi}, 64'd0);
    check_val("arst_lo", {32'd0, lo}, 64'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MULT, 32'd6, 32'd7, 1'b0);

    // Randomized mix of all ops including reserved/NOP and MT writes
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
